poly_note_player_ctrl: RTL
==========================

// Module: poly_note_player_ctrl
// PURPOSE
//  Multi-voice note sequencing controller for the music player datapath.
//  One independent FSM plus an internal duration down-counter per voice.
//  Each FSM issues a one-cycle load strobe to its note register, counts the
//  note length in beat ticks, then reports completion with a one-cycle done pulse.
//  Sits between the song reader / beat generator and the per-voice frequency generators.
//  Supports global pause and per-voice retrigger.
// PARAMETERS
//  NUM_VOICES  3   number of independent voices, >= 1
//  DUR_W       6   width of one duration field, in beats
// PORTS
//  clk            in   1              system clock
//  reset          in   1              synchronous, active-high
//  play_enable    in   1              global run; low aborts every voice
//  pause          in   1              freeze all duration counters; beats ignored
//  beat           in   1              one-cycle beat tick from the beat generator
//  load_new_note  in   NUM_VOICES     per-voice request to start a note
//  note_duration  in   NUM_VOICES*DUR_W  voice v duration at [v*DUR_W +: DUR_W]
//  load           out  NUM_VOICES     one-cycle strobe: latch new note for voice v
//  note_done      out  NUM_VOICES     one-cycle pulse: voice v finished its note
//  voice_busy     out  NUM_VOICES     voice v is in LOAD or PLAY
//  all_done       out  1              one-cycle pulse on the cycle the last busy voice reaches DONE
//  active_count   out  $clog2(NUM_VOICES+1)  popcount of voice_busy
// BEHAVIOUR
//  Reset:
//   - all FSMs go to IDLE and all counters clear to 0.
//   - load, note_done, voice_busy and all_done are 0; active_count is 0.
//  Per-voice FSM states: IDLE, LOAD, PLAY, DONE. Outputs are decoded from the registered state (Moore).
//   - IDLE: play_enable && load_new_note[v] -> LOAD; otherwise stay.
//   - LOAD: load[v]=1; cnt <= note_duration[v] (0 loads as 1); -> PLAY.
//     A beat in the LOAD cycle is not counted.
//   - PLAY: on beat && !pause, cnt decrements. If cnt==1 on that beat -> DONE.
//   - DONE: note_done[v]=1; -> LOAD if play_enable && load_new_note[v], else -> IDLE.
//  Retrigger:
//   - load_new_note[v] in PLAY -> LOAD next cycle, which restarts cnt.
//   - Retrigger beats a simultaneous final beat: no note_done is issued for the abandoned note.
//  Abort:
//   - play_enable=0 in any state -> IDLE next cycle; cnt clears; no note_done.
//   - Abort has priority over load_new_note, beat and retrigger.
//  Pause:
//   - holds cnt and state in PLAY.
//   - Does not block the IDLE->LOAD or LOAD->PLAY transitions.
//   - Does not block retrigger or abort.
//  Latency:
//   - Request sampled in cycle N -> load high in cycle N+1 -> PLAY from N+2.
//   - note_done appears in the cycle after the D-th counted beat.
//  all_done:
//   - Registered: asserted for one cycle when at least one voice enters DONE this cycle
//     and no voice remains in LOAD/PLAY next cycle.
//  Counter arithmetic:
//   - cnt is DUR_W bits and never wraps below 1 in PLAY.
//   - Maximum duration is 2^DUR_W-1 beats.
//  Voices share only play_enable, pause and beat. No arbitration between voices is required.
// TESTING
//  1. Reset mid-PLAY with cnt=5 -> next cycle all outputs 0, active_count 0, voice back in IDLE.
//  2. Voice0, duration 3, beat every 4 cycles:
//     load[0] one cycle after the request; note_done[0] one cycle after the 3rd beat; all_done together with it.
//  3. Duration 0 -> behaves as duration 1: note_done one cycle after the first counted beat.
//  4. Voice1 duration 4; pause high across beats 2-3 -> those beats are ignored;
//     done after the 4th counted beat.
//  5. Voice2 retrigger on the final beat -> load[2] re-pulses, no note_done[2], and the count restarts.
//  6. Voices 0 and 1 playing, play_enable drops -> both IDLE next cycle, no note_done, no all_done.

Source files
------------

// File: rtl/poly_note_player_ctrl_if.sv
// Interface between the song reader / beat generator and the voice sequencing controller.
// The master drives the transport controls; the slave is the controller.
interface poly_note_player_ctrl_if #(
  parameter int NUM_VOICES = 3,
  parameter int DUR_W      = 6
);
  localparam int CNT_W = $clog2(NUM_VOICES + 1);

  logic                        play_enable;
  logic                        pause;
  logic                        beat;
  logic [NUM_VOICES-1:0]       load_new_note;
  logic [NUM_VOICES*DUR_W-1:0] note_duration;
  logic [NUM_VOICES-1:0]       load;
  logic [NUM_VOICES-1:0]       note_done;
  logic [NUM_VOICES-1:0]       voice_busy;
  logic                        all_done;
  logic [CNT_W-1:0]            active_count;

  modport master (
    output play_enable, pause, beat, load_new_note, note_duration,
    input  load, note_done, voice_busy, all_done, active_count
  );

  modport slave (
    input  play_enable, pause, beat, load_new_note, note_duration,
    output load, note_done, voice_busy, all_done, active_count
  );
endinterface

// File: rtl/poly_note_player_ctrl.sv
// Multi-voice note sequencer: one IDLE/LOAD/PLAY/DONE FSM and beat down-counter per voice,
// with global abort (play_enable low), global pause and per-voice retrigger.
module poly_note_player_ctrl #(
  parameter int NUM_VOICES = 3,
  parameter int DUR_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  poly_note_player_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_VOICES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  state_t           state     [NUM_VOICES];
  state_t           state_nxt [NUM_VOICES];
  logic [DUR_W-1:0] cnt       [NUM_VOICES];
  logic [DUR_W-1:0] cnt_nxt   [NUM_VOICES];
  logic [DUR_W-1:0] dur       [NUM_VOICES];
  logic             all_done_q;
  logic             all_done_nxt;

  logic [NUM_VOICES-1:0] load_o;
  logic [NUM_VOICES-1:0] done_o;
  logic [NUM_VOICES-1:0] busy_o;
  logic [CNT_W-1:0]      count_o;

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      dur[v] = bus.note_duration[v*DUR_W +: DUR_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state[v] <= IDLE;
        cnt[v]   <= '0;
      end
      all_done_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state[v] <= state_nxt[v];
        cnt[v]   <= cnt_nxt[v];
      end
      all_done_q <= all_done_nxt;
    end
  end

  // Abort outranks everything; inside PLAY a retrigger outranks the beat.
  always_comb begin
    logic entering_done;
    logic still_busy;
    entering_done = 1'b0;
    still_busy    = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      state_nxt[v] = state[v];
      cnt_nxt[v]   = cnt[v];
      if (!bus.play_enable) begin
        state_nxt[v] = IDLE;
        cnt_nxt[v]   = '0;
      end else begin
        case (state[v])
          IDLE: if (bus.load_new_note[v]) state_nxt[v] = LOAD;
          LOAD: begin
            state_nxt[v] = PLAY;
            cnt_nxt[v]   = (dur[v] == '0) ? DUR_W'(1) : dur[v];
          end
          PLAY: begin
            if (bus.load_new_note[v]) begin
              state_nxt[v] = LOAD;
            end else if (bus.beat && !bus.pause) begin
              cnt_nxt[v] = cnt[v] - DUR_W'(1);
              if (cnt[v] == DUR_W'(1)) state_nxt[v] = DONE;
            end
          end
          DONE:    state_nxt[v] = bus.load_new_note[v] ? LOAD : IDLE;
          default: state_nxt[v] = IDLE;
        endcase
      end
      if (state_nxt[v] == DONE && state[v] != DONE) entering_done = 1'b1;
      if (state_nxt[v] == LOAD || state_nxt[v] == PLAY) still_busy = 1'b1;
    end
    all_done_nxt = entering_done && !still_busy;
  end

  always_comb begin
    load_o  = '0;
    done_o  = '0;
    busy_o  = '0;
    count_o = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      load_o[v] = (state[v] == LOAD);
      done_o[v] = (state[v] == DONE);
      busy_o[v] = (state[v] == LOAD) || (state[v] == PLAY);
      count_o   = count_o + CNT_W'(busy_o[v]);
    end
  end

  assign bus.load         = load_o;
  assign bus.note_done    = done_o;
  assign bus.voice_busy   = busy_o;
  assign bus.active_count = count_o;
  assign bus.all_done     = all_done_q;
endmodule
